// File: rtl/pc_pkg.sv
// Shared definitions for the fetch/PC sequencer and the PC register it controls.
//   pc_op_e : operation encoding on nextPCop, shared with the PC register
//   state_e : sequencer states
package pc_pkg;

  typedef enum logic [1:0] {
    PC_OP_NOP    = 2'b00,
    PC_OP_INC    = 2'b01,
    PC_OP_ASSIGN = 2'b10,
    PC_OP_RESET  = 2'b11
  } pc_op_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Instruction-memory fetch handshake between the PC sequencer and instruction memory.
//   imem_req    : fetch request (sequencer -> memory)
//   imem_addr   : fetch address (sequencer -> memory)
//   imem_ready  : instruction returned this cycle (memory -> sequencer)
//   instr_valid : fetched instruction valid for decode (sequencer -> decode)
interface pc_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;

  modport master (
    output imem_req,
    output imem_addr,
    output instr_valid,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  instr_valid,
    output imem_ready
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch/PC sequencer: runs boot -> fetch -> execute, handshakes with instruction memory,
// and chooses the next PC (sequential, branch, interrupt vector, trap vector, trap return).
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   pc                : current PC from the PC register
//   nextPC, nextPCop  : control of the PC register
//   intVec            : high in the cycle an interrupt redirect is issued
//   imem              : fetch handshake (master side)
//   exec_done         : core finished the current instruction
//   branch_taken/branch_target, mret : redirect qualifiers, valid with exec_done
//   irq, irq_en       : level interrupt request and global enable
//   epc               : saved return PC
//   misaligned        : one-cycle pulse on a misaligned-branch trap
module pc_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h0000_0010,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic [31:0]       nextPC,
  output pc_op_e            nextPCop,
  output logic              intVec,
  pc_ctrl_if.master         imem,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              mret,
  input  logic              irq,
  input  logic              irq_en,
  output logic [31:0]       epc,
  output logic              misaligned
);

  state_e      state_q, state_d;
  logic        in_trap_q, in_trap_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_plus4;
  logic        take_irq;
  logic        bad_branch;

  assign pc_plus4   = pc + 32'd4;
  assign take_irq   = irq & irq_en & ~in_trap_q;
  assign bad_branch = branch_taken & (branch_target[1:0] != 2'b00);

  assign imem.imem_addr   = pc;
  assign imem.instr_valid = (state_q == S_FETCH) & imem.imem_ready;
  assign epc              = epc_q;

  always_comb begin
    state_d       = state_q;
    in_trap_d     = in_trap_q;
    epc_d         = epc_q;
    nextPC        = RESET_VEC;
    nextPCop      = PC_OP_NOP;
    intVec        = 1'b0;
    misaligned    = 1'b0;
    imem.imem_req = 1'b0;

    case (state_q)
      S_BOOT: begin
        nextPCop = PC_OP_ASSIGN;
        nextPC   = RESET_VEC;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_FETCH;
          if (take_irq) begin
            // The branch target is saved as the return point even if misaligned.
            nextPCop  = PC_OP_ASSIGN;
            nextPC    = IRQ_VEC;
            intVec    = 1'b1;
            in_trap_d = 1'b1;
            epc_d     = branch_taken ? branch_target : pc_plus4;
          end else if (bad_branch) begin
            // Nested traps are allowed; the earlier epc is lost.
            nextPCop   = PC_OP_ASSIGN;
            nextPC     = TRAP_VEC;
            misaligned = 1'b1;
            in_trap_d  = 1'b1;
            epc_d      = pc;
          end else if (mret) begin
            nextPCop  = PC_OP_ASSIGN;
            nextPC    = epc_q;
            in_trap_d = 1'b0;
          end else if (branch_taken) begin
            nextPCop = PC_OP_ASSIGN;
            nextPC   = branch_target;
          end else begin
            nextPCop = PC_OP_INC;
          end
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      in_trap_q <= 1'b0;
      epc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      in_trap_q <= in_trap_d;
      epc_q     <= epc_d;
    end
  end

endmodule
